// File: rtl/pipe_csa_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, with carries
// and the not-yet-consumed operand bits passed down the pipe in registers.
module pipe_csa_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ofOut,
  output logic             zero
);

  localparam int unsigned NSEG = WIDTH / SEG;

  if (SEG < 2 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipe_csa_adder: SEG must be in 2..WIDTH and divide WIDTH");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;
  logic             of_q;

  // Subtraction is A + ~B + ~Cin, folded in before the first stage.
  assign b_eff   = sub ? ~B : B;
  assign cin_eff = Cin ^ sub;

  // Both candidate sums are formed; the incoming carry only drives the final select.
  function automatic logic [SEG:0] csel_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c);
    logic [SEG:0] r0;
    logic [SEG:0] r1;
    r0 = {1'b0, a} + {1'b0, b};
    r1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    return c ? r1 : r0;
  endfunction

  for (genvar g = 0; g < NSEG; g++) begin : g_stage
    localparam int unsigned Lo = g * SEG;
    localparam int unsigned Hi = Lo + SEG - 1;

    // Operand bits still to be consumed from this stage upward.
    logic [WIDTH-1:Lo] op_a;
    logic [WIDTH-1:Lo] op_b;
    logic              cin_s;
    logic              zin_s;
    logic              vin_s;
    logic [SEG:0]      seg;
    logic [Hi:0]       sum_d;
    logic [Hi:0]       sum_q;
    logic              cy_q;
    logic              zero_q;
    logic              valid_q;

    assign seg = csel_add(op_a[Hi:Lo], op_b[Hi:Lo], cin_s);

    if (g == 0) begin : g_in
      assign op_a  = A;
      assign op_b  = b_eff;
      assign cin_s = cin_eff;
      assign zin_s = 1'b1;
      assign vin_s = in_valid && in_ready;
      assign sum_d = seg[SEG-1:0];
    end else begin : g_in
      assign op_a  = g_stage[g-1].g_rem.a_q;
      assign op_b  = g_stage[g-1].g_rem.b_q;
      assign cin_s = g_stage[g-1].cy_q;
      assign zin_s = g_stage[g-1].zero_q;
      assign vin_s = g_stage[g-1].valid_q;
      assign sum_d = {seg[SEG-1:0], g_stage[g-1].sum_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        cy_q    <= 1'b0;
        zero_q  <= 1'b0;
      end else if (advance) begin
        valid_q <= vin_s;
        sum_q   <= sum_d;
        cy_q    <= seg[SEG];
        zero_q  <= zin_s && (seg[SEG-1:0] == '0);
      end
    end

    if (g < NSEG - 1) begin : g_rem
      logic [WIDTH-1:Hi+1] a_q;
      logic [WIDTH-1:Hi+1] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= op_a[WIDTH-1:Hi+1];
          b_q <= op_b[WIDTH-1:Hi+1];
        end
      end
    end

    if (g == NSEG - 1) begin : g_last
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          of_q <= 1'b0;
        end else if (advance) begin
          of_q <= seg[SEG] ^ seg[SEG-1] ^ op_a[Hi] ^ op_b[Hi];
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;

  assign Sum   = g_stage[NSEG-1].sum_q;
  assign Cout  = g_stage[NSEG-1].cy_q;
  assign ofOut = of_q;
  assign zero  = g_stage[NSEG-1].zero_q;

endmodule

// File: doc/pipe_csa_adder.md
# pipe_csa_adder

Parametrised, pipelined carry-select adder/subtractor. It is the next-generation replacement for the fixed 32-bit, single-split combinational carry-select adder in the simple ALU. The operand width and segment size are generic, and there is one pipeline stage per segment. Carries pass between stages through registers, so the critical path is one segment. The ALU feeds it through a valid/ready handshake and reads back the sum, carry, overflow and zero flags.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SEG.
- SEG, 8, segment width in bits (2..WIDTH); NSEG = WIDTH/SEG is the number of pipeline stages.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result this cycle.
- Sum  output  WIDTH  result.
- Cout  output  1  raw carry out of the MSB.
- ofOut  output  1  two's-complement signed overflow.
- zero  output  1  Sum == 0.

## Operation
- Effective operation:
  - sub=0: Sum = A + B + Cin.
  - sub=1: Sum = A + ~B + ~Cin, which is A - B - Cin. Cout=1 means no borrow.
- The B inversion and carry-in inversion happen at the input, before stage 1.
- Stage k (k = 1..NSEG) handles bits [k*SEG-1:(k-1)*SEG]:
  - Two SEG-bit ripple sums are formed, one with carry-in 0 and one with carry-in 1.
  - The registered carry from stage k-1 selects between them. Stage 1 uses the effective carry-in.
- Operand bits not yet consumed travel down the pipeline as skewed registers alongside the partial sum.
- The final stage's outputs:
  - Cout = carry out of bit WIDTH-1.
  - ofOut = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (Sum == 0).
- All arithmetic is modulo 2^WIDTH. There is no saturation.
- Global stall rule: advance = !out_valid || out_ready.
  - in_ready = advance && !rst.
  - When advance=0, every stage register (data and valid) holds.
  - When advance=1, every stage shifts by one. A stage with no valid data shifts a bubble (valid=0).
- The input is accepted when in_valid && in_ready. If in_valid=0 while advancing, a bubble enters.
- Results leave in strict acceptance order. None are dropped or duplicated.

## Timing
- Latency: a bundle accepted at edge t produces out_valid=1 in the cycle after edge t+NSEG-1, provided no stall occurs. That is NSEG cycles (4 for 32/8; 1 for SEG=WIDTH).
- Throughput: one result per cycle while out_ready=1.
- Stalls add exactly one cycle per cycle of out_ready=0 while out_valid=1.
- While out_valid=1 && out_ready=0:
  - Sum, Cout, ofOut and zero are stable.
  - in_ready=0.
- in_ready depends combinationally on out_ready, out_valid and rst. There are no other combinational input-to-output paths.
- Reset, applied in any cycle:
  - At the next edge, all stage valid bits are cleared, and Sum, Cout, ofOut and zero are set to 0.
  - out_valid=0 from the cycle after the reset edge.
  - in_ready=0 while rst=1.
- In-flight operations at reset are discarded and never appear at the output.
- A bundle presented in the same cycle as rst=1 is not accepted.
- Simultaneous output handoff and input acceptance in one cycle is legal and required for full throughput.

## Test plan
All tests use WIDTH=32, SEG=8 unless noted.
- Carry chain: A=0xFFFFFFFF, B=0x00000001, Cin=0, sub=0 → 4 cycles later Sum=0x00000000, Cout=1, ofOut=0, zero=1.
- Signed overflow: A=0x7FFFFFFF, B=1, sub=0 → Sum=0x80000000, Cout=0, ofOut=1. Also A=0x80000000, B=0xFFFFFFFF → Sum=0x7FFFFFFF, Cout=1, ofOut=1.
- Subtract: A=5, B=7, Cin=0, sub=1 → Sum=0xFFFFFFFE, Cout=0, ofOut=0. A=0x80000000, B=1, sub=1 → Sum=0x7FFFFFFF, Cout=1, ofOut=1. A=9, B=4, Cin=1, sub=1 → Sum=4, Cout=1.
- Streaming: 8 random bundles on consecutive cycles with out_ready=1 → 8 consecutive out_valid cycles starting 4 cycles after the first. The results match a reference model in order.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles → in_ready=0, and Sum and flags are held stable. After release, all results arrive in order with none lost.
- Reset mid-flight and parameter sweep: 2 bundles in flight, assert rst for 1 cycle → out_valid=0 afterwards, and neither result ever appears. Repeat the carry-chain test with SEG=32 (latency 1) and WIDTH=16, SEG=4 (latency 4).
